// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Contents: funct3 opcode encodings, FSM state constants, default data width,
// and helpers that tell whether an opcode treats each operand as signed.
package ex_muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic op1_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_divstep.sv
// Combinational restoring-division step retiring DIV_BITS quotient bits.
// Ports: rem/num/den  - partial remainder, dividend being shifted out
//                       (quotient bits shift in at the bottom), divisor
//        rem_next/num_next - values after DIV_BITS steps
module ex_muldiv_divstep
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] num,
  input  logic [XLEN-1:0] den,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] num_next
);

  logic [XLEN:0] trial;

  always_comb begin
    rem_next = rem;
    num_next = num;
    trial    = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial    = {rem_next, num_next[XLEN-1]};
      num_next = {num_next[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, den}) begin
        trial       = trial - {1'b0, den};
        num_next[0] = 1'b1;
      end
      // After a restoring step the remainder is below den, so the top bit is 0.
      rem_next = trial[XLEN-1:0];
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Ports: clk, rst (async, active-high), flush (abort in-flight op)
//        req_valid/req_ready/req_opcode/req_op1/req_op2 - operation request
//        resp_valid/resp_ready/resp_result              - result handshake
//        stall_req - pipeline stall while busy without a result
// Work runs on magnitudes; the sign is applied once at the end. The last two
// iteration slots negate the accumulator (full product for MULH*) and then
// register the selected half as the result.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int MUL_BITS = 1,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            stall_req
);

  localparam int CW = $clog2(XLEN) + 1;
  // One slot per step, plus a fix-up slot and a select slot.
  localparam logic [CW-1:0] MUL_CNT = CW'(XLEN / MUL_BITS + 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(XLEN / DIV_BITS + 1);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [2:0]        opcode;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;      // {hi, lo}: product, or {remainder, dividend/quotient}
  logic              neg_lo;   // product / quotient sign
  logic              neg_hi;   // remainder sign
  logic [XLEN-1:0]   result;

  logic            s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2;

  assign s1       = op1_signed(req_opcode) & req_op1[XLEN-1];
  assign s2       = op2_signed(req_opcode) & req_op2[XLEN-1];
  assign mag1     = s1 ? -req_op1 : req_op1;
  assign mag2     = s2 ? -req_op2 : req_op2;
  assign div_zero = (req_op2 == '0);
  assign div_ovf  = ((req_opcode == OP_DIV) || (req_opcode == OP_REM)) &&
                    (req_op1 == INT_MIN) && (req_op2 == '1);

  // Shift-add multiply step: add opb * low multiplier bits into the high half,
  // then shift the whole accumulator right by MUL_BITS.
  logic [XLEN+MUL_BITS-1:0]   mul_sum;
  logic [2*XLEN+MUL_BITS-1:0] mul_cat;
  logic [2*XLEN-1:0]          mul_next;

  always_comb begin
    mul_sum = {{MUL_BITS{1'b0}}, acc[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc[i]) mul_sum = mul_sum + ({{MUL_BITS{1'b0}}, opb} << i);
    end
    mul_cat  = {mul_sum, acc[XLEN-1:0]} >> MUL_BITS;
    mul_next = mul_cat[2*XLEN-1:0];
  end

  logic [XLEN-1:0] div_rem, div_quo;

  ex_muldiv_divstep #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_divstep (
    .rem      (acc[2*XLEN-1:XLEN]),
    .num      (acc[XLEN-1:0]),
    .den      (opb),
    .rem_next (div_rem),
    .num_next (div_quo)
  );

  logic [2*XLEN-1:0] acc_fix;
  logic              sel_hi;

  always_comb begin
    if (state == ST_MUL) acc_fix = neg_lo ? -acc : acc;
    else acc_fix = {neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN],
                    neg_lo ? -acc[XLEN-1:0]      : acc[XLEN-1:0]};
  end

  // High half for MULH/MULHSU/MULHU and REM/REMU; low half for MUL and DIV/DIVU.
  assign sel_hi = (opcode != OP_MUL) && !(opcode[2] && !opcode[1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      opcode <= '0;
      cnt    <= '0;
      opb    <= '0;
      acc    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            opcode <= req_opcode;
            neg_lo <= s1 ^ s2;
            neg_hi <= s1 & req_opcode[2];
            if (req_opcode[2]) begin
              opb <= mag2;
              acc <= {{XLEN{1'b0}}, mag1};
              cnt <= DIV_CNT;
              if (div_zero) begin
                result <= req_opcode[1] ? req_op1 : '1;
                state  <= ST_DONE;
              end else if (div_ovf) begin
                result <= req_opcode[1] ? '0 : req_op1;
                state  <= ST_DONE;
              end else begin
                state <= ST_DIV;
              end
            end else begin
              opb   <= mag1;
              acc   <= {{XLEN{1'b0}}, mag2};
              cnt   <= MUL_CNT;
              state <= ST_MUL;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt == '0) begin
            result <= sel_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
            state  <= ST_DONE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1))      acc <= acc_fix;
            else if (state == ST_MUL) acc <= mul_next;
            else                    acc <= {div_rem, div_quo};
          end
        end
        default: begin
          if (resp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE) & ~flush;
  assign resp_valid  = (state == ST_DONE);
  assign resp_result = result;
  assign stall_req   = (state == ST_MUL) || (state == ST_DIV) ||
                       ((state == ST_IDLE) & req_valid & ~flush);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  // 32-bit, 1 bit/cycle instance
  logic        a_req_valid = 1'b0, a_req_ready, a_resp_valid, a_resp_ready = 1'b1, a_stall;
  logic [2:0]  a_opcode = '0;
  logic [31:0] a_op1 = '0, a_op2 = '0, a_result;

  // 64-bit, radix-16 multiply / radix-4 divide instance
  logic        b_req_valid = 1'b0, b_req_ready, b_resp_valid, b_resp_ready = 1'b1, b_stall;
  logic [2:0]  b_opcode = '0;
  logic [63:0] b_op1 = '0, b_op2 = '0, b_result;

  ex_muldiv #(.XLEN(32), .MUL_BITS(1), .DIV_BITS(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_opcode(a_opcode),
    .req_op1(a_op1), .req_op2(a_op2),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_result(a_result),
    .stall_req(a_stall)
  );

  ex_muldiv #(.XLEN(64), .MUL_BITS(4), .DIV_BITS(2)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_opcode(b_opcode),
    .req_op1(b_op1), .req_op2(b_op2),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_result(b_result),
    .stall_req(b_stall)
  );

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] sb32[$];
  logic [63:0] sb64[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model on 128-bit signed arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] x,
                                        input logic [63:0] y, input int xl);
    logic signed [127:0] sx, sy, ux, uy, r;
    logic [63:0] mask;
    mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    ux = {64'b0, x & mask};
    uy = {64'b0, y & mask};
    sx = (xl == 32) ? {{96{x[31]}}, x[31:0]} : {{64{x[63]}}, x};
    sy = (xl == 32) ? {{96{y[31]}}, y[31:0]} : {{64{y[63]}}, y};
    case (op)
      3'd0:    r = sx * sy;
      3'd1:    r = (sx * sy) >>> xl;
      3'd2:    r = (sx * uy) >>> xl;
      3'd3:    r = (ux * uy) >>> xl;
      3'd4:    r = (uy == 0) ? -128'sd1 : sx / sy;
      3'd5:    r = (uy == 0) ? -128'sd1 : ux / uy;
      3'd6:    r = (uy == 0) ? sx : sx % sy;
      default: r = (uy == 0) ? ux : ux % uy;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [63:0] x,
                                      input logic [63:0] y, input logic [63:0] min_v,
                                      input logic [63:0] ones);
    return op[2] && ((y == 0) || (((op == OP_DIV) || (op == OP_REM)) && x == min_v && y == ones));
  endfunction

  // Latency is counted in edges after the accepting edge; special divides are
  // already in DONE right after the accepting edge.
  task automatic run32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int hold);
    int edges;
    int exp_lat;
    logic [63:0] e;
    exp_lat = is_special(op, {32'b0, x}, {32'b0, y}, 64'h8000_0000, 64'hFFFF_FFFF) ? 0 : 34;
    @(negedge clk);
    a_resp_ready = (hold == 0);
    a_opcode = op; a_op1 = x; a_op2 = y; a_req_valid = 1'b1;
    sb32.push_back({32'b0, exp});
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_op1 = ~x; a_op2 = ~y;
    if (exp_lat != 0) check("stall32_busy", a_stall, 1);
    edges = 0;
    while (!a_resp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb32.pop_front();
    check("lat32", edges, exp_lat);
    check("res32", a_result, e);
    check("stall32_done", a_stall, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold32_valid", a_resp_valid, 1);
      check("hold32_res", a_result, e);
      check("hold32_ready", a_req_ready, 0);
    end
    @(negedge clk); a_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("ack32_valid", a_resp_valid, 0);
    check("ack32_ready", a_req_ready, 1);
  endtask

  task automatic run64(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y,
                       input int hold);
    int edges;
    int exp_lat;
    logic [63:0] e;
    if (is_special(op, x, y, 64'h8000_0000_0000_0000, '1)) exp_lat = 0;
    else exp_lat = op[2] ? (64 / 2 + 2) : (64 / 4 + 2);
    @(negedge clk);
    b_resp_ready = (hold == 0);
    b_opcode = op; b_op1 = x; b_op2 = y; b_req_valid = 1'b1;
    sb64.push_back(model(op, x, y, 64));
    @(posedge clk); #1;
    b_req_valid = 1'b0; b_op1 = '0; b_op2 = '0;
    edges = 0;
    while (!b_resp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    e = sb64.pop_front();
    check($sformatf("lat64 op%0d", op), edges, exp_lat);
    check($sformatf("res64 op%0d %h %h", op, x, y), b_result, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold64_res", b_resp_valid ? b_result : ~e, e);
    end
    @(negedge clk); b_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("ack64_valid", b_resp_valid, 0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [63:0] x, y;
    logic        seen;

    #2;
    check("rst_ready", a_req_ready, 1);
    check("rst_valid", a_resp_valid, 0);
    check("rst_stall", a_stall, 0);
    check("rst_result", a_result, 0);
    check("rst64_result", b_result, 0);
    @(negedge clk); rst = 1'b0;

    run32(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run32(OP_MULHU,  32'd7,          32'hFFFF_FFFD, 32'h0000_0006, 0);
    run32(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
    run32(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run32(OP_DIVU,   32'd100,        32'd7,         32'd14,        5);
    run32(OP_REMU,   32'd100,        32'd7,         32'd2,         0);
    run32(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    run32(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    run32(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run32(OP_REM,    32'd5,          32'd0,         32'd5,         0);
    run32(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run32(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
    run32(OP_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);

    // Flush partway through a divide.
    @(negedge clk);
    a_opcode = OP_DIV; a_op1 = 32'd1000; a_op2 = 32'd3; a_req_valid = 1'b1;
    @(posedge clk); #1 a_req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", a_resp_valid, 0);
    check("flush_stall", a_stall, 0);
    check("flush_ready", a_req_ready, 0);
    @(negedge clk); a_req_valid = 1'b1;
    #1 check("flush_req_stall", a_stall, 0);
    @(posedge clk); #1;
    @(negedge clk); flush = 1'b0; a_req_valid = 1'b0;
    #1 check("flush_not_accepted", a_req_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_resp_valid) seen = 1'b1;
    end
    check("flush_no_resp", seen, 0);
    run32(OP_MUL, 32'd3, 32'd4, 32'd12, 0);

    // 64-bit random operations against the model.
    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      x  = {$urandom, $urandom};
      y  = {$urandom, $urandom};
      if (k % 4 == 1) y = y >> 40;
      if (k % 6 == 0) y = '0;
      if (k == 7) begin op = OP_DIV; x = 64'h8000_0000_0000_0000; y = '1; end
      run64(op, x, y, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    a_opcode = OP_MUL; a_op1 = 32'd9; a_op2 = 32'd9; a_req_valid = 1'b1;
    @(posedge clk); #1 a_req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", a_req_ready, 1);
    check("midrst_stall", a_stall, 0);
    check("midrst_valid", a_resp_valid, 0);
    check("midrst_result", a_result, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
